// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states and port ids.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the requester that was not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, or zero when nobody is asking.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-ported word memory with
// combinational read data. Each access takes two cycles: accept, then access;
// the completion pulse overlaps the next acceptance window.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [BIT_WIDTH-1:0] req0_addr,
  input  logic [BIT_WIDTH-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_done,
  output logic [BIT_WIDTH-1:0] req0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [BIT_WIDTH-1:0] req1_addr,
  input  logic [BIT_WIDTH-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_done,
  output logic [BIT_WIDTH-1:0] req1_rdata,
  output logic                 mem_write,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata
);

  state_t     state;
  logic       last_grant;
  logic       lat_port;
  logic [1:0] grant;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready only while idle and out of reset, so an access in flight blocks new requests.
  always_comb begin
    req0_ready = reset_n && (state == IDLE) && grant[0];
    req1_ready = reset_n && (state == IDLE) && grant[1];
  end

  // Accept/access FSM; mem_write doubles as the latched write flag during ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= PORT1;
      lat_port   <= PORT0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[1]) begin
            lat_port   <= PORT1;
            last_grant <= PORT1;
            mem_write  <= req1_write;
            mem_addr   <= req1_addr;
            mem_wdata  <= req1_wdata;
            state      <= ACCESS;
          end else if (grant[0]) begin
            lat_port   <= PORT0;
            last_grant <= PORT0;
            mem_write  <= req0_write;
            mem_addr   <= req0_addr;
            mem_wdata  <= req0_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          state     <= IDLE;
          if (lat_port == PORT1) begin
            req1_done <= 1'b1;
            if (!mem_write) req1_rdata <= mem_rdata;
          end else begin
            req0_done <= 1'b1;
            if (!mem_write) req0_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions, hand
// sequences for contention, abort and ignored requests, and a scoreboard that
// pairs every acceptance with its completion pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_write, req0_ready, req0_done;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.BIT_WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Power-on contents of the memory; 0x10 carries a recognisable marker word.
  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hCAFEBABE;
    return {8'hA5, i[7:0], 8'h5A, ~i[7:0]};
  endfunction

  // Behavioural word memory with combinational read, loaded on the first edge.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic port_ready(logic p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic port_done(logic p);
    return p ? req1_done : req0_done;
  endfunction

  function automatic logic [31:0] port_rdata(logic p);
    return p ? req1_rdata : req0_rdata;
  endfunction

  // Scoreboard: acceptances are queued, completions pop and compare against
  // a shadow copy of memory that is updated only when a write completes.
  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb [$];
  txn_t        sb_head;
  logic [31:0] shadow [256];
  logic        shadow_loaded = 1'b0;

  always @(negedge clk) begin
    if (!shadow_loaded) begin
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      shadow_loaded = 1'b1;
    end
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (req0_done || req1_done) begin
        if (req0_done && req1_done) check_output("sb_two_dones", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          check_output("sb_unexpected_done", {31'd0, req1_done}, 32'hFFFFFFFF);
        end else begin
          sb_head = sb.pop_front();
          check_output("sb_done_port", {31'd0, req1_done}, {31'd0, sb_head.port});
          if (sb_head.write) shadow[sb_head.addr[7:0]] = sb_head.wdata;
          else check_output("sb_rdata", port_rdata(sb_head.port), shadow[sb_head.addr[7:0]]);
        end
      end
      if (req0_ready && req1_ready) check_output("sb_both_ready", 32'd1, 32'd0);
      if (req0_valid && req0_ready) sb.push_back('{1'b0, req0_write, req0_addr, req0_wdata});
      if (req1_valid && req1_ready) sb.push_back('{1'b1, req1_write, req1_addr, req1_wdata});
    end
  end

  // Hold reset with both requesters asking; nothing may be ready and all outputs clear.
  task automatic do_reset(string name);
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output({name, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check_output({name, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check_output({name, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check_output({name, "_mem_addr"}, mem_addr, 32'd0);
    check_output({name, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({name, "_done"}, {30'd0, req1_done, req0_done}, 32'd0);
    check_output({name, "_rdata0"}, req0_rdata, 32'd0);
    check_output({name, "_rdata1"}, req1_rdata, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  // One isolated transaction with cycle-exact checks of accept, access and completion.
  task automatic apply_stimulus(vec_t v, string name);
    logic [31:0] old_rdata;
    int          waited;
    old_rdata = port_rdata(v.port);
    if (v.port) begin
      req1_valid = 1'b1; req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata;
    end
    waited = 0;
    @(negedge clk);
    while (!port_ready(v.port) && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_output({name, "_accept_latency"}, waited, 32'd0);
    check_output({name, "_idle_mem_write"}, {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_output({name, "_access_addr"}, mem_addr, v.addr);
    check_output({name, "_access_wdata"}, mem_wdata, v.wdata);
    check_output({name, "_access_write"}, {31'd0, mem_write}, {31'd0, v.write});
    check_output({name, "_access_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    check_output({name, "_done"}, {31'd0, port_done(v.port)}, 32'd1);
    check_output({name, "_other_done"}, {31'd0, port_done(!v.port)}, 32'd0);
    check_output({name, "_rdata"}, port_rdata(v.port), v.write ? old_rdata : v.exp_rdata);
    check_output({name, "_done_mem_write"}, {31'd0, mem_write}, 32'd0);
    check_output({name, "_hold_addr"}, mem_addr, v.addr);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [7];
  logic port_log [6];
  int   cyc_log [6];
  int   acc, cyc, done_cnt0, done_cnt1, ready_cnt0;

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hCAFEBABE};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'h30, 32'h0BADF00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h30, 32'hFFFFFFFF, 32'h0BADF00D};
    vecs[6] = '{1'b1, 1'b0, 32'h04, 32'h0,        init_word(4)};

    do_reset("reset_a");
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Contention straight after reset: requester 0 first, requester 1 in the done cycle.
    do_reset("reset_b");
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h4;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h8;
    @(negedge clk);
    check_output("contend_first_ready0", {31'd0, req0_ready}, 32'd1);
    check_output("contend_first_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check_output("contend_access_ready1", {31'd0, req1_ready}, 32'd0);
    check_output("contend_access_addr", mem_addr, 32'h4);
    @(negedge clk);
    check_output("contend_done0", {31'd0, req0_done}, 32'd1);
    check_output("contend_rdata0", req0_rdata, init_word(4));
    check_output("contend_second_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    check_output("contend_access_addr1", mem_addr, 32'h8);
    check_output("contend_no_done1_yet", {31'd0, req1_done}, 32'd0);
    @(negedge clk);
    check_output("contend_done1", {31'd0, req1_done}, 32'd1);
    check_output("contend_rdata1", req1_rdata, init_word(8));
    @(posedge clk); #1;

    // Both held valid for six accesses: strict alternation at one access per two cycles.
    do_reset("reset_c");
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h1;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h2;
    acc = 0;
    cyc = 0;
    while (acc < 6 && cyc < 30) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        port_log[acc] = req1_ready;
        cyc_log[acc]  = cyc;
        acc++;
      end
      if (acc < 6) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_output("rr_accept_count", acc, 32'd6);
    for (int i = 0; i < acc; i++) begin
      check_output($sformatf("rr_grant%0d", i), {31'd0, port_log[i]}, 32'(i % 2));
      if (i > 0) check_output($sformatf("rr_spacing%0d", i), cyc_log[i] - cyc_log[i-1], 32'd2);
    end
    repeat (2) @(posedge clk);
    #1;

    // A one-cycle req0 pulse during an access must vanish without trace.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h8;
    @(negedge clk);
    check_output("pulse_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h4;
    @(negedge clk);
    check_output("pulse_req0_ready_in_access", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    done_cnt0 = 0; done_cnt1 = 0; ready_cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_cnt0 += int'(req0_done);
      done_cnt1 += int'(req1_done);
      ready_cnt0 += int'(req0_ready);
      @(posedge clk); #1;
    end
    check_output("pulse_req0_done_count", done_cnt0, 32'd0);
    check_output("pulse_req0_ready_count", ready_cnt0, 32'd0);
    check_output("pulse_req1_done_count", done_cnt1, 32'd1);
    check_output("sb_drained", sb.size(), 32'd0);

    // Reset in the middle of a write access: write drops at once, memory untouched, no done.
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h40; req1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_output("abort_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1 check_output("abort_write_before", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("abort_write_after", {31'd0, mem_write}, 32'd0);
    done_cnt1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      done_cnt1 += int'(req1_done);
    end
    check_output("abort_mem_unchanged", mem[8'h40], init_word(8'h40));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      done_cnt1 += int'(req1_done);
    end
    check_output("abort_no_done", done_cnt1, 32'd0);
    check_output("abort_mem_after", mem[8'h40], init_word(8'h40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 32, SHALL set the width of every address and data port.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req0_valid  input  1  SHALL indicate that requester 0 (instruction fetch) presents a request.
REQ-005 req0_write  input  1  SHALL select a write (1) or a read (0) for requester 0.
REQ-006 req0_addr  input  BIT_WIDTH  SHALL be the word address for requester 0.
REQ-007 req0_wdata  input  BIT_WIDTH  SHALL be the write data for requester 0.
REQ-008 req0_ready  output  1  SHALL indicate that requester 0's request is accepted this cycle.
REQ-009 req0_done  output  1  SHALL be a one-cycle completion pulse for requester 0.
REQ-010 req0_rdata  output  BIT_WIDTH  SHALL carry requester 0's read data, valid while req0_done is high after a read.
REQ-011 req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done and req1_rdata SHALL mirror REQ-004 to REQ-010 for requester 1 (data load/store).
REQ-012 mem_write  output  1  SHALL be the write enable to the word memory.
REQ-013 mem_addr  output  BIT_WIDTH  SHALL be the memory read/write address.
REQ-014 mem_wdata  output  BIT_WIDTH  SHALL be the memory write data.
REQ-015 mem_rdata  input  BIT_WIDTH  SHALL be the memory's combinational read data for mem_addr.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-017 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester N, and only when reqN_valid is high.
REQ-018 When only one requester is valid in IDLE, that requester SHALL be granted.
REQ-019 When both requesters are valid in IDLE, the requester not granted last SHALL be granted (round-robin).
REQ-020 At the rising edge where valid&&ready holds, the block SHALL latch the port id, write flag, addr and wdata, update last_grant, and go to ACCESS.
REQ-021 In ACCESS, mem_addr and mem_wdata SHALL equal the latched values, and mem_write SHALL equal the latched write flag.
REQ-022 In IDLE, mem_write SHALL be 0, and mem_addr and mem_wdata SHALL hold their last latched values.
REQ-023 At the edge that ends ACCESS, the block SHALL register mem_rdata into the latched port's rdata, pulse that port's done for exactly the next cycle (for reads and writes alike), and return to IDLE.
REQ-024 Latency: accept edge N, memory access in cycle N+1, done and rdata visible in cycle N+2.
REQ-025 A new request SHALL be acceptable in the same cycle that done is high (IDLE), giving a throughput of one access per 2 cycles.
REQ-026 No reqN_ready SHALL be high in ACCESS; requesters must hold valid, addr and data stable until ready.
REQ-027 reqN_rdata SHALL hold its value until that port's next read completes; a write completion SHALL leave it unchanged.
REQ-028 A requester deasserting valid before acceptance SHALL be ignored, with no state change.

Reset
REQ-029 While reset_n is low, the block SHALL be in IDLE, mem_write=0, mem_addr=0, mem_wdata=0, both done=0, both rdata=0, and last_grant=1, so requester 0 wins the first contention.
REQ-030 Reset asserted during ACCESS SHALL abort the access immediately, with no done pulse and no write after the reset asserts.
REQ-031 Both ready outputs SHALL be 0 while reset_n is low.

Structure
REQ-032 The state encoding (IDLE=0, ACCESS=1) and the port-id constants SHALL live in the shared package mem_arb_pkg.
REQ-033 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: valid[1:0], last_grant; output: grant[1:0], one-hot or zero); everything else stays in mem_arbiter.

Verification
REQ-034 The bench SHALL check: after reset, req1 reads 0x10 alone (mem[0x10]=0xCAFEBABE) -> req1_ready in cycle 0, mem_addr=0x10 in cycle 1, req1_done=1 with req1_rdata=0xCAFEBABE in cycle 2.
REQ-035 The bench SHALL check: after reset, both requesters are valid (req0 read 0x4, req1 read 0x8) -> req0 is served first, req1 is accepted in req0's done cycle, and req1_done follows 2 cycles later.
REQ-036 The bench SHALL check: both requesters are held continuously valid for 6 accesses -> grants alternate 0,1,0,1,0,1 with no starvation.
REQ-037 The bench SHALL check: req1 writes 0x12345678 to 0x20, then req0 reads 0x20 -> mem_write is high for exactly one cycle, and req0_rdata=0x12345678.
REQ-038 The bench SHALL check: reset_n is pulled low during ACCESS of a req1 write -> mem_write drops at once, no done pulse occurs, and the memory location is unchanged if reset precedes the edge.
REQ-039 The bench SHALL check: req0_valid is pulsed for one cycle while the block is in ACCESS -> the request is never accepted and no done pulse occurs.
